ram_port_arbiter: RTL and testbench

- Shares the single unified RAM port between two requesters: m0 (CPU fetch/load/store path) and m1 (DMA / boot-loader master).
- Uses a req/ack handshake on each side. Latches each granted request and sequences it through the RAM's fixed read latency.
- Sits between the CPU top level and the RAM model. The CPU stalls on its memory states until m0_ack.

---
 rtl/ram_port_arbiter.sv | 123 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Purpose: two-master (m0 CPU, m1 DMA) req/ack arbiter in front of a single-port RAM.
// Latency: write ack at t+2, read ack at t+2+RD_LAT (t = IDLE cycle the req is sampled in).
// Backpressure: a requester holds req until its one-cycle ack. Requests are only considered in IDLE.
// Optional build macro RAM_ARB_FIXED_PRIO_EN: m0 always wins a tie instead of round-robin.
module ram_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1    // RAM read latency in cycles, legal range 1..4
) (
  input  logic          clk,
  input  logic          reset,      // asynchronous, active-low
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t     state;
  logic       lat_we;     // latched direction of the granted request
  logic [2:0] cnt;        // read latency countdown, reaches 1 on the data cycle
  logic       last;       // master of the most recently completed transaction
  logic       grant_m1;   // arbitration result, only meaningful in IDLE with a req

  // Pick the master to grant when at least one req is high in IDLE.
  always_comb begin
    grant_m1 = 1'b0;
`ifdef RAM_ARB_FIXED_PRIO_EN
    // m0 wins every tie; last is still tracked but not consulted.
    grant_m1 = m1_req & ~m0_req;
`else
    // On a tie grant the master that did not complete last.
    grant_m1 = m1_req & (~m0_req | ~last);
`endif
  end

  // Transaction sequencer: grant, drive the RAM, wait out the read latency, pulse ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      cnt       <= 3'd0;
      last      <= 1'b1;   // so m0 wins the first tie
      owner     <= 1'b0;
      busy      <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      // Strobes are single-cycle; the state arms below re-assert them as needed.
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      ram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            // The RAM address/data registers double as the request latch, so they
            // naturally hold their value outside ISSUE.
            owner     <= grant_m1;
            lat_we    <= grant_m1 ? m1_we    : m0_we;
            ram_we    <= grant_m1 ? m1_we    : m0_we;
            ram_addr  <= grant_m1 ? m1_addr  : m0_addr;
            ram_wdata <= grant_m1 ? m1_wdata : m0_wdata;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (lat_we) begin
            // Write lands at the end of this cycle; complete straight away.
            m0_ack <= ~owner;
            m1_ack <= owner;
            state  <= DONE;
          end else begin
            cnt   <= 3'(RD_LAT);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd1) begin
            // Read data is valid this cycle; only the owner's register updates.
            if (owner) m1_rdata <= ram_rdata;
            else       m0_rdata <= ram_rdata;
            m0_ack <= ~owner;
            m1_ack <= owner;
            state  <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          last  <= owner;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Purpose: directed stimulus for ram_port_arbiter with a queue-based ack scoreboard.
// Latency: acks are checked against hand-computed cycle numbers (RD_LAT = 3).
// Backpressure: requesters hold req until ack, then drop or re-present it.
module tb_ram_port_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int RD_LAT = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy;
  logic          owner;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  typedef struct packed {
    logic        master;
    logic        is_rd;
    logic [31:0] rdata;
    int unsigned cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .owner(owner)
  );

  // RAM model: word array, read data delayed RD_LAT cycles after the address.
  logic [31:0] mem  [0:255];
  logic [31:0] pipe [0:RD_LAT-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;
    pipe[0] <= mem[ram_addr[9:2]];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[RD_LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push(input logic m, input logic rd, input logic [31:0] d, input int unsigned t);
    exp_t e;
    e.master = m; e.is_rd = rd; e.rdata = d; e.cyc = t;
    exp_q.push_back(e);
  endtask

  // Monitor: every ack pops one expected completion and is checked against it.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && (m0_ack || m1_ack)) begin
        chk("ack_exclusive", {63'd0, m0_ack & m1_ack}, 64'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_ack: m0_ack=%0b m1_ack=%0b at cycle %0d, none expected",
                   m0_ack, m1_ack, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ack_master", {63'd0, m1_ack}, {63'd0, mon_e.master});
          chk("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("owner_at_ack", {63'd0, owner}, {63'd0, mon_e.master});
          if (mon_e.is_rd)
            chk("ack_rdata", 64'(mon_e.master ? m1_rdata : m0_rdata), 64'(mon_e.rdata));
        end
      end
    end
  end

  initial begin
    int unsigned c;

    // T1: reset with both reqs high, then m0 write wins, then m1 read of the same word.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h100; m0_wdata = 32'hDEADBEEF;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h100; m1_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_acks", {62'd0, m0_ack, m1_ack}, 64'd0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
    chk("rst_ram_we", {63'd0, ram_we}, 64'd0);
    chk("rst_ram_bus", {ram_addr, ram_wdata}, 64'd0);
    chk("rst_owner_busy", {62'd0, owner, busy}, 64'd0);
    reset = 1'b1;
    c = cyc;
    push(1'b0, 1'b0, 32'h0, c + 2);
    push(1'b1, 1'b1, 32'hDEADBEEF, c + 5 + RD_LAT);
    @(negedge clk);                       // ISSUE
    chk("t1_issue_we", {63'd0, ram_we}, 64'd1);
    chk("t1_issue_addr", 64'(ram_addr), 64'h100);
    chk("t1_issue_wdata", 64'(ram_wdata), 64'hDEADBEEF);
    chk("t1_owner_busy", {62'd0, owner, busy}, 64'd1);
    @(negedge clk);                       // DONE of m0
    chk("t1_done_we", {63'd0, ram_we}, 64'd0);
    chk("t1_addr_held", 64'(ram_addr), 64'h100);
    m0_req = 1'b0;
    wait_until(c + 5 + RD_LAT);
    m1_req = 1'b0;
    @(negedge clk);

    // T2: both masters requesting continuously for six write transactions.
    c = cyc;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h200; m0_wdata = 32'hA0A0A0A0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h204; m1_wdata = 32'hB1B1B1B1;
    for (int k = 0; k < 6; k++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      push(1'b0, 1'b0, 32'h0, c + 2 + 3 * k);
`else
      push(1'(k % 2), 1'b0, 32'h0, c + 2 + 3 * k);
`endif
    end
    wait_until(c + 17);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);

    // T3: m1 writes a word, m0 reads it back; m1_rdata must keep its old value.
    c = cyc;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h104; m1_wdata = 32'h12345678;
    push(1'b1, 1'b0, 32'h0, c + 2);
    wait_until(c + 2);
    m1_req = 1'b0;
    @(negedge clk);
    c = cyc;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h104;
    push(1'b0, 1'b1, 32'h12345678, c + 2 + RD_LAT);
    wait_until(c + 2 + RD_LAT);
    m0_req = 1'b0;
    chk("t3_m1_rdata_held", 64'(m1_rdata), 64'hDEADBEEF);
    @(negedge clk);

    // T4: m0 drops req during ISSUE of its write; the write still completes, then m1 reads it.
    c = cyc;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h300; m0_wdata = 32'hCAFEF00D;
    push(1'b0, 1'b0, 32'h0, c + 2);
    push(1'b1, 1'b1, 32'hCAFEF00D, c + 5 + RD_LAT);
    @(negedge clk);                       // ISSUE
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h300;
    chk("t4_issue_we", {63'd0, ram_we}, 64'd1);
    chk("t4_issue_addr", 64'(ram_addr), 64'h300);
    wait_until(c + 5 + RD_LAT);
    m1_req = 1'b0;
    @(negedge clk);

    // T5: reset asserted while an m1 read is waiting on RAM data.
    c = cyc;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h100;
    wait_until(c + 3);                    // inside WAIT
    chk("t5_busy_before", {63'd0, busy}, 64'd1);
    #2;
    reset = 1'b0;
    m1_req = 1'b0;
    #1;
    chk("t5_rst_busy_owner", {62'd0, busy, owner}, 64'd0);
    chk("t5_rst_acks", {62'd0, m0_ack, m1_ack}, 64'd0);
    chk("t5_rst_ram_bus", {ram_addr, ram_wdata}, 64'd0);
    chk("t5_rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t5_idle_we_busy", {62'd0, ram_we, busy}, 64'd0);
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
